// File: rtl/pe_mem_access_arbiter.sv
// Shares one single-ported SRAM between NUM_LANES DMA lanes (round-robin) and the load/store unit (exclusive grant).
// Readys and SRAM controls are combinational; read data returns one cycle after accept; lanes not selected see ready=0.
module pe_mem_access_arbiter #(
    parameter int NUM_LANES = 32,
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          reset_poweron,
    input  logic [NUM_LANES-1:0]          dma__memc__write_valid,
    input  logic [NUM_LANES*ADDR_W-1:0]   dma__memc__write_address,
    input  logic [NUM_LANES*DATA_W-1:0]   dma__memc__write_data,
    output logic [NUM_LANES-1:0]          memc__dma__write_ready,
    input  logic [NUM_LANES-1:0]          dma__memc__read_valid,
    input  logic [NUM_LANES*ADDR_W-1:0]   dma__memc__read_address,
    output logic [NUM_LANES-1:0]          memc__dma__read_ready,
    output logic [DATA_W-1:0]             memc__dma__read_data,
    output logic [NUM_LANES-1:0]          memc__dma__read_data_valid,
    input  logic                          ldst__memc__request,
    output logic                          memc__ldst__granted,
    input  logic                          ldst__memc__released,
    input  logic                          ldst__memc__write_valid,
    input  logic [ADDR_W-1:0]             ldst__memc__write_address,
    input  logic [DATA_W-1:0]             ldst__memc__write_data,
    input  logic                          ldst__memc__read_valid,
    input  logic [ADDR_W-1:0]             ldst__memc__read_address,
    output logic [DATA_W-1:0]             memc__ldst__read_data,
    output logic                          memc__ldst__read_data_valid,
    output logic                          memc__mem__enable,
    output logic                          memc__mem__write,
    output logic [ADDR_W-1:0]             memc__mem__address,
    output logic [DATA_W-1:0]             memc__mem__write_data,
    input  logic [DATA_W-1:0]             mem__memc__read_data
);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {ST_DMA, ST_DRAIN, ST_GRANT} state_e;

    state_e              state_q, state_d;
    logic [LANE_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic                rd_pend_q, rd_pend_d;
    logic                rd_ldst_q, rd_ldst_d;
    logic [LANE_W-1:0]   rd_lane_q, rd_lane_d;

    logic [NUM_LANES-1:0] elig;
    logic                 found;
    logic [LANE_W-1:0]    win;
    logic [LANE_W:0]      cand;

    logic [NUM_LANES-1:0] wr_rdy, rd_rdy, dvld_vec;
    logic                 mem_en, mem_wr;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic                 active, dma_rvld, ldst_rvld;

    assign elig   = dma__memc__write_valid | dma__memc__read_valid;
    assign active = !reset_poweron;

    // First eligible lane scanning upward from rr_ptr, wrapping past the last lane.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            cand = {1'b0, rr_ptr_q} + (LANE_W+1)'(i);
            if (cand >= (LANE_W+1)'(NUM_LANES)) cand = cand - (LANE_W+1)'(NUM_LANES);
            if (!found && elig[cand[LANE_W-1:0]]) begin
                found = 1'b1;
                win   = cand[LANE_W-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        rd_pend_d = 1'b0;
        rd_ldst_d = 1'b0;
        rd_lane_d = rd_lane_q;
        wr_rdy    = '0;
        rd_rdy    = '0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            ST_DMA: begin
                if (found) begin
                    rr_ptr_d = (win == LANE_W'(NUM_LANES-1)) ? '0 : win + 1'b1;
                    mem_en   = 1'b1;
                    if (dma__memc__write_valid[win]) begin
                        wr_rdy[win] = 1'b1;
                        mem_wr      = 1'b1;
                        mem_addr    = dma__memc__write_address[win*ADDR_W +: ADDR_W];
                        mem_wdata   = dma__memc__write_data[win*DATA_W +: DATA_W];
                    end else begin
                        rd_rdy[win] = 1'b1;
                        mem_addr    = dma__memc__read_address[win*ADDR_W +: ADDR_W];
                        rd_pend_d   = 1'b1;
                        rd_lane_d   = win;
                    end
                end
                if (ldst__memc__request) state_d = ST_DRAIN;
            end
            // One idle cycle so an in-flight DMA read returns before ownership moves.
            ST_DRAIN: state_d = ST_GRANT;
            ST_GRANT: begin
                if (ldst__memc__write_valid) begin
                    mem_en    = 1'b1;
                    mem_wr    = 1'b1;
                    mem_addr  = ldst__memc__write_address;
                    mem_wdata = ldst__memc__write_data;
                end else if (ldst__memc__read_valid) begin
                    mem_en    = 1'b1;
                    mem_addr  = ldst__memc__read_address;
                    rd_pend_d = 1'b1;
                    rd_ldst_d = 1'b1;
                end
                if (ldst__memc__released) state_d = ST_DMA;
            end
            default: state_d = ST_DMA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state_q   <= ST_DMA;
            rr_ptr_q  <= '0;
            rd_pend_q <= 1'b0;
            rd_ldst_q <= 1'b0;
            rd_lane_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            rd_pend_q <= rd_pend_d;
            rd_ldst_q <= rd_ldst_d;
            rd_lane_q <= rd_lane_d;
        end
    end

    assign dma_rvld  = active && rd_pend_q && !rd_ldst_q;
    assign ldst_rvld = active && rd_pend_q && rd_ldst_q;

    always_comb begin
        dvld_vec = '0;
        if (dma_rvld) dvld_vec[rd_lane_q] = 1'b1;
    end

    assign memc__dma__write_ready      = active ? wr_rdy : '0;
    assign memc__dma__read_ready       = active ? rd_rdy : '0;
    assign memc__dma__read_data_valid  = dvld_vec;
    assign memc__dma__read_data        = dma_rvld ? mem__memc__read_data : '0;
    assign memc__ldst__read_data_valid = ldst_rvld;
    assign memc__ldst__read_data       = ldst_rvld ? mem__memc__read_data : '0;
    assign memc__ldst__granted         = active && (state_q == ST_GRANT);
    assign memc__mem__enable           = active && mem_en;
    assign memc__mem__write            = active && mem_wr;
    assign memc__mem__address          = active ? mem_addr : '0;
    assign memc__mem__write_data       = active ? mem_wdata : '0;
endmodule

// File: tb/tb_pe_mem_access_arbiter.sv
// Randomised and directed bench for pe_mem_access_arbiter against a behavioural arbitration/memory model.
module tb_pe_mem_access_arbiter;
    localparam int N  = 32;
    localparam int AW = 24;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [N-1:0]  wv, rv;
    logic [N*AW-1:0] waddr, raddr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]  wr_rdy, rd_rdy, dvld;
    logic [DW-1:0] dd;
    logic          req, gr, rel, lwv, lrv, lvld;
    logic [AW-1:0] lwaddr, lraddr;
    logic [DW-1:0] lwdata, ldata;
    logic          men, mwr;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwdata, mrdata;

    pe_mem_access_arbiter #(.NUM_LANES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset_poweron(rst),
        .dma__memc__write_valid(wv), .dma__memc__write_address(waddr), .dma__memc__write_data(wdata),
        .memc__dma__write_ready(wr_rdy),
        .dma__memc__read_valid(rv), .dma__memc__read_address(raddr),
        .memc__dma__read_ready(rd_rdy), .memc__dma__read_data(dd), .memc__dma__read_data_valid(dvld),
        .ldst__memc__request(req), .memc__ldst__granted(gr), .ldst__memc__released(rel),
        .ldst__memc__write_valid(lwv), .ldst__memc__write_address(lwaddr), .ldst__memc__write_data(lwdata),
        .ldst__memc__read_valid(lrv), .ldst__memc__read_address(lraddr),
        .memc__ldst__read_data(ldata), .memc__ldst__read_data_valid(lvld),
        .memc__mem__enable(men), .memc__mem__write(mwr), .memc__mem__address(maddr),
        .memc__mem__write_data(mwdata), .mem__memc__read_data(mrdata)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state: mode 0=DMA owns memory, 1=drain, 2=load/store owns memory.
    int m_mode = 0, m_rr = 0, m_plane = 0;
    bit m_pend = 0, m_pl = 0;
    logic [DW-1:0] m_pdata = '0;
    int n_mode, n_rr, n_plane;
    bit n_pend, n_pl;
    logic [DW-1:0] n_pdata;

    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] sram    [logic [AW-1:0]];
    bit            sr_wr;
    logic [AW-1:0] sr_waddr;
    logic [DW-1:0] sr_wdata, sr_next;

    function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
        return {8'h5A, a};
    endfunction

    function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] sram_rd(logic [AW-1:0] a);
        return sram.exists(a) ? sram[a] : init_val(a);
    endfunction

    function automatic logic [N-1:0] oh(int i);
        logic [N-1:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Mid-cycle: predict this cycle's outputs from the model, compare, and prepare next model state.
    task automatic sample();
        logic [N-1:0]  e_wr, e_rd, e_dv;
        logic [DW-1:0] e_dd, e_ld, e_wd;
        logic          e_gr, e_lv, e_en, e_w;
        logic [AW-1:0] e_a;
        int w;
        @(negedge clk);
        e_wr = '0; e_rd = '0; e_dv = '0; e_dd = '0; e_ld = '0; e_wd = '0;
        e_gr = 0; e_lv = 0; e_en = 0; e_w = 0; e_a = '0;
        n_mode = m_mode; n_rr = m_rr; n_pend = 0; n_pl = 0; n_plane = 0; n_pdata = '0;
        if (rst) begin
            n_mode = 0;
            n_rr   = 0;
        end else begin
            if (m_pend) begin
                if (m_pl) begin e_lv = 1; e_ld = m_pdata; end
                else begin e_dv[m_plane] = 1'b1; e_dd = m_pdata; end
            end
            if (m_mode == 0) begin
                w = -1;
                for (int j = 0; j < N; j++) begin
                    int l;
                    l = (m_rr + j) % N;
                    if (w < 0 && (wv[l] || rv[l])) w = l;
                end
                if (w >= 0) begin
                    n_rr = (w + 1) % N;
                    e_en = 1;
                    if (wv[w]) begin
                        e_wr[w] = 1'b1; e_w = 1;
                        e_a  = waddr[w*AW +: AW];
                        e_wd = wdata[w*DW +: DW];
                        ref_mem[e_a] = e_wd;
                    end else begin
                        e_rd[w] = 1'b1;
                        e_a = raddr[w*AW +: AW];
                        n_pend = 1; n_plane = w; n_pdata = ref_rd(e_a);
                    end
                end
                if (req) n_mode = 1;
            end else if (m_mode == 1) begin
                n_mode = 2;
            end else begin
                e_gr = 1;
                if (lwv) begin
                    e_en = 1; e_w = 1; e_a = lwaddr; e_wd = lwdata;
                    ref_mem[e_a] = e_wd;
                end else if (lrv) begin
                    e_en = 1; e_a = lraddr;
                    n_pend = 1; n_pl = 1; n_pdata = ref_rd(e_a);
                end
                if (rel) n_mode = 0;
            end
        end
        check("wr_ready", 64'(wr_rdy), 64'(e_wr));
        check("rd_ready", 64'(rd_rdy), 64'(e_rd));
        check("dma_dvld", 64'(dvld), 64'(e_dv));
        check("dma_data", 64'(dd), 64'(e_dd));
        check("granted", 64'(gr), 64'(e_gr));
        check("ldst_dvld", 64'(lvld), 64'(e_lv));
        check("ldst_data", 64'(ldata), 64'(e_ld));
        check("mem_en", 64'(men), 64'(e_en));
        check("mem_wr", 64'(mwr), 64'(e_w));
        check("mem_addr", 64'(maddr), 64'(e_a));
        check("mem_wdata", 64'(mwdata), 64'(e_wd));
        // The SRAM stand-in reacts to what the DUT actually drives.
        sr_wr    = men && mwr;
        sr_waddr = maddr;
        sr_wdata = mwdata;
        sr_next  = (men && !mwr) ? sram_rd(maddr) : DW'($urandom);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (sr_wr) sram[sr_waddr] = sr_wdata;
        mrdata  = sr_next;
        m_mode  = n_mode;  m_rr = n_rr; m_pend = n_pend;
        m_pl    = n_pl;    m_plane = n_plane; m_pdata = n_pdata;
    endtask

    task automatic clear_inputs();
        wv = '0; rv = '0; req = 0; rel = 0; lwv = 0; lrv = 0;
    endtask

    initial begin
        int dens;
        int pick;
        rst = 1; mrdata = '0; sr_wr = 0; sr_next = '0;
        clear_inputs();
        lwaddr = '0; lraddr = '0; lwdata = '0;
        for (int i = 0; i < N; i++) begin
            waddr[i*AW +: AW] = AW'(32'h100 + i);
            raddr[i*AW +: AW] = AW'(32'h100 + i);
            wdata[i*DW +: DW] = DW'($urandom);
        end

        // Reset held with every request active: all outputs quiet.
        wv = '1; rv = '1; req = 1; lwv = 1; lrv = 1;
        for (int k = 0; k < 3; k++) begin
            sample();
            check("rst_wr_ready", 64'(wr_rdy), 64'd0);
            check("rst_rd_ready", 64'(rd_rdy), 64'd0);
            check("rst_granted", 64'(gr), 64'd0);
            check("rst_mem_en", 64'(men), 64'd0);
            advance();
        end
        rst = 0; req = 0; lwv = 0; lrv = 0;
        sample();
        check("first_grant_lane0", 64'(wr_rdy), 64'd1);
        advance();
        rst = 1; clear_inputs();
        sample(); advance();
        rst = 0;

        // All lanes reading: strict rotation, data one cycle behind.
        for (int i = 0; i < N; i++) raddr[i*AW +: AW] = AW'(32'h20 + i);
        for (int k = 0; k <= 33; k++) begin
            rv = (k < 33) ? '1 : '0;
            sample();
            if (k < 33) check("rot_ready", 64'(rd_rdy), 64'(oh(k % N)));
            if (k >= 1) begin
                check("rot_dvld", 64'(dvld), 64'(oh((k - 1) % N)));
                check("rot_data", 64'(dd), 64'({8'h5A, AW'(32'h20 + (k - 1) % N)}));
            end
            advance();
        end

        // Write by lane 5 seen by a later read from lane 9.
        wv = oh(5); waddr[5*AW +: AW] = 24'h10; wdata[5*DW +: DW] = 32'hDEADBEEF;
        sample(); check("l5_write_ready", 64'(wr_rdy), 64'(oh(5))); advance();
        wv = '0; rv = oh(9); raddr[9*AW +: AW] = 24'h10;
        sample(); check("l9_read_ready", 64'(rd_rdy), 64'(oh(9))); advance();
        rv = '0;
        sample();
        check("l9_dvld", 64'(dvld), 64'(oh(9)));
        check("l9_data", 64'(dd), 64'h0000_0000_DEAD_BEEF);
        advance();

        // Load/store takeover in the middle of DMA streaming (pointer sits at lane 10).
        for (int i = 0; i < N; i++) raddr[i*AW +: AW] = AW'(i);
        lraddr = 24'h10; lwaddr = 24'h11; lwdata = 32'hCAFEF00D;
        for (int c = 0; c <= 22; c++) begin
            rv  = (c < 22) ? '1 : '0;
            req = (c >= 10 && c < 20);
            rel = (c == 20);
            lrv = (c == 12);
            lwv = (c == 15);
            sample();
            if (c == 0)  check("stream_start", 64'(rd_rdy), 64'(oh(10)));
            if (c == 10) check("req_cycle_ready", 64'(rd_rdy), 64'(oh(20)));
            if (c == 11) begin
                check("drain_ready", 64'(rd_rdy), 64'd0);
                check("drain_mem_en", 64'(men), 64'd0);
                check("drain_granted", 64'(gr), 64'd0);
            end
            if (c == 12) begin
                check("grant_first", 64'(gr), 64'd1);
                check("grant_ready", 64'(rd_rdy), 64'd0);
            end
            if (c == 13) begin
                check("ldst_dvld_lit", 64'(lvld), 64'd1);
                check("ldst_data_lit", 64'(ldata), 64'h0000_0000_DEAD_BEEF);
            end
            if (c == 20) check("grant_at_release", 64'(gr), 64'd1);
            if (c == 21) begin
                check("granted_dropped", 64'(gr), 64'd0);
                check("dma_resume", 64'(rd_rdy), 64'(oh(21)));
            end
            advance();
        end
        clear_inputs();

        // Wrap from lane 31 to lane 0, then write-before-read on one lane.
        rv = oh(30);
        sample(); check("l30_ready", 64'(rd_rdy), 64'(oh(30))); advance();
        rv = oh(31) | oh(0);
        sample(); check("wrap_l31", 64'(rd_rdy), 64'(oh(31))); advance();
        rv = oh(0);
        sample(); check("wrap_l0", 64'(rd_rdy), 64'(oh(0))); advance();
        wv = oh(3); rv = oh(3);
        sample();
        check("wr_first", 64'(wr_rdy), 64'(oh(3)));
        check("rd_held", 64'(rd_rdy), 64'd0);
        advance();
        wv = '0;
        sample(); check("rd_next_turn", 64'(rd_rdy), 64'(oh(3))); advance();

        // Reset right after a read accept drops the return.
        rv = oh(7); raddr[7*AW +: AW] = 24'h5;
        sample(); check("pre_rst_read", 64'(rd_rdy), 64'(oh(7))); advance();
        rv = '0; rst = 1;
        sample();
        check("rst_drop_dvld", 64'(dvld), 64'd0);
        check("rst_drop_gr", 64'(gr), 64'd0);
        advance();
        rst = 0;
        sample();
        check("post_rst_dvld", 64'(dvld), 64'd0);
        check("post_rst_gr", 64'(gr), 64'd0);
        advance();

        // Random traffic checked against the model every cycle.
        dens = 20;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 256 == 0) dens = $urandom_range(2, 90);
            rst = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < N; i++) begin
                wv[i] = ($urandom_range(0, 99) < dens);
                rv[i] = ($urandom_range(0, 99) < dens);
                waddr[i*AW +: AW] = AW'($urandom_range(0, 31));
                raddr[i*AW +: AW] = AW'($urandom_range(0, 31));
                wdata[i*DW +: DW] = DW'($urandom);
            end
            lwaddr = AW'($urandom_range(0, 31));
            lraddr = AW'($urandom_range(0, 31));
            lwdata = DW'($urandom);
            pick = $urandom_range(0, 2);
            lwv = (pick == 1);
            lrv = (pick == 2);
            if (m_mode == 2) begin
                rel = ($urandom_range(0, 5) == 0);
                if (rel) req = ($urandom_range(0, 1) == 1);
            end else begin
                rel = 0;
                if (!req) req = ($urandom_range(0, 29) == 0);
            end
            sample();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
